// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker
// Trace consumer for the single-cycle CPU. Each retired instruction's PC and
// result are compared against a preloaded expected-trace table. The block
// reports pass/fail, a saturating mismatch count and the index of the first
// mismatching sample.
//
// Ports:
//   clk            rising-edge clock shared with the CPU
//   rst_n          asynchronous active-low reset
//   exp_we         write one expected-trace entry (ignored while running)
//   exp_idx        entry index to write
//   exp_addr       expected PC for that entry
//   exp_result     expected result for that entry
//   trace_len      number of entries to check, sampled on start (clamped to DEPTH)
//   start          one-cycle pulse that begins a check run
//   sample_en      CPU retired an instruction; addr/result are valid
//   addr           CPU PC
//   result         CPU result
//   busy           a run is in progress
//   done           the run has finished; result outputs are stable
//   pass           valid with done; 1 means no mismatches
//   mismatch_cnt   number of mismatching samples, saturating
//   first_fail_idx index of the first mismatch, 0 if none
//   cur_idx        number of samples consumed in this run
module cpu_trace_checker #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          exp_we,
    input  logic [AW-1:0] exp_idx,
    input  logic [31:0]   exp_addr,
    input  logic [31:0]   exp_result,
    input  logic [AW:0]   trace_len,
    input  logic          start,
    input  logic          sample_en,
    input  logic [31:0]   addr,
    input  logic [31:0]   result,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] mismatch_cnt,
    output logic [AW-1:0] first_fail_idx,
    output logic [AW:0]   cur_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] tbl_addr   [DEPTH];
    logic [31:0] tbl_result [DEPTH];

    logic [AW:0]   len;
    logic [AW:0]   len_clamped;
    logic [AW:0]   cur_idx_inc;
    logic [CW-1:0] cnt_inc;
    logic          launch;
    logic          consume;
    logic          sample_bad;
    logic          last;

    // Expected-trace table. Deliberately not reset: contents survive a reset
    // so a run can be retried without reloading.
    always_ff @(posedge clk) begin
        if (exp_we && state != RUN) begin
            tbl_addr[exp_idx]   <= exp_addr;
            tbl_result[exp_idx] <= exp_result;
        end
    end

    // Shared decode of the current cycle. A start in IDLE/DONE takes priority
    // over any sample presented in the same cycle, which is simply dropped.
    always_comb begin
        len_clamped = (trace_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : trace_len;
        launch      = start && (state != RUN);
        consume     = sample_en && (state == RUN);
        sample_bad  = (tbl_addr[cur_idx[AW-1:0]] != addr) ||
                      (tbl_result[cur_idx[AW-1:0]] != result);
        cur_idx_inc = cur_idx + (AW+1)'(1);
        last        = (cur_idx_inc == len);
        cnt_inc     = (mismatch_cnt == '1) ? mismatch_cnt : mismatch_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length run goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (sample_en && last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and run bookkeeping. busy/done are derived from the
    // next state so they line up with the state register without adding an
    // input-to-output combinational path. A zero mismatch count means no
    // failure has been seen yet, since the saturating counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            cur_idx        <= '0;
            len            <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (launch) begin
                len            <= len_clamped;
                mismatch_cnt   <= '0;
                first_fail_idx <= '0;
                cur_idx        <= '0;
                pass           <= (len_clamped == '0);
            end else if (consume) begin
                cur_idx <= cur_idx_inc;
                if (sample_bad) begin
                    mismatch_cnt <= cnt_inc;
                    if (mismatch_cnt == '0) begin
                        first_fail_idx <= cur_idx[AW-1:0];
                    end
                end
                if (last) begin
                    pass <= !sample_bad && (mismatch_cnt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Testbench for cpu_trace_checker. A main instance (CW=8) and a narrow-counter
// instance (CW=2) see identical stimulus; expected run results are computed
// from a bench-side copy of the table and queued when a run is launched.
module tb_cpu_trace_checker;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int CW     = 8;
    localparam int CW_SAT = 2;

    logic              clk;
    logic              rst_n;
    logic              exp_we;
    logic [AW-1:0]     exp_idx;
    logic [31:0]       exp_addr;
    logic [31:0]       exp_result;
    logic [AW:0]       trace_len;
    logic              start;
    logic              sample_en;
    logic [31:0]       addr;
    logic [31:0]       result;

    logic              busy, done, pass;
    logic [CW-1:0]     mismatch_cnt;
    logic [AW-1:0]     first_fail_idx;
    logic [AW:0]       cur_idx;

    logic              busy_s, done_s, pass_s;
    logic [CW_SAT-1:0] mismatch_cnt_s;
    logic [AW-1:0]     first_fail_idx_s;
    logic [AW:0]       cur_idx_s;

    typedef struct {
        logic        pass;
        logic [31:0] cnt;
        logic [31:0] cnt_sat;
        logic [31:0] ffi;
        logic [31:0] cur;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_addr   [DEPTH];
    logic [31:0] model_result [DEPTH];
    logic [31:0] samp_addr    [DEPTH];
    logic [31:0] samp_result  [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          base_done;

    cpu_trace_checker #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_result(exp_result), .trace_len(trace_len),
        .start(start), .sample_en(sample_en), .addr(addr), .result(result),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail_idx(first_fail_idx), .cur_idx(cur_idx)
    );

    cpu_trace_checker #(.DEPTH(DEPTH), .AW(AW), .CW(CW_SAT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_result(exp_result), .trace_len(trace_len),
        .start(start), .sample_en(sample_en), .addr(addr), .result(result),
        .busy(busy_s), .done(done_s), .pass(pass_s), .mismatch_cnt(mismatch_cnt_s),
        .first_fail_idx(first_fail_idx_s), .cur_idx(cur_idx_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic load_entry(input int i, input logic [31:0] a, input logic [31:0] r);
        exp_we     = 1'b1;
        exp_idx    = AW'(i);
        exp_addr   = a;
        exp_result = r;
        @(posedge clk); #1;
        exp_we          = 1'b0;
        model_addr[i]   = a;
        model_result[i] = r;
    endtask

    task automatic samples_match();
        for (int i = 0; i < DEPTH; i++) begin
            samp_addr[i]   = model_addr[i];
            samp_result[i] = model_result[i];
        end
    endtask

    // Launches a run, queues its expected outcome, feeds the samples (with an
    // optional stall before sample stall_at) and waits a bounded time for done.
    task automatic drive_run(input int len, input int stall_at, input int stall_n,
                             input bit we_in_run, output int done_cycle,
                             output int busy_cycles);
        int   eff;
        int   mism;
        int   ffi;
        int   cycle;
        exp_t e;
        eff  = (len > DEPTH) ? DEPTH : len;
        mism = 0;
        ffi  = 0;
        for (int i = 0; i < eff; i++) begin
            if (samp_addr[i] !== model_addr[i] || samp_result[i] !== model_result[i]) begin
                if (mism == 0) ffi = i;
                mism++;
            end
        end
        e.pass    = (mism == 0);
        e.cnt     = (mism > 255) ? 255 : mism;
        e.cnt_sat = (mism > 3) ? 3 : mism;
        e.ffi     = ffi;
        e.cur     = eff;
        sb.push_back(e);

        start     = 1'b1;
        trace_len = (AW+1)'(len);
        sample_en = 1'b1;
        addr      = 32'hDEAD_BEEF;
        result    = $urandom;
        @(posedge clk); #1;
        start       = 1'b0;
        done_cycle  = -1;
        busy_cycles = 0;
        cycle       = 0;
        for (int i = 0; i < eff; i++) begin
            if (i == stall_at) begin
                repeat (stall_n) begin
                    sample_en = 1'b0;
                    addr      = $urandom;
                    result    = $urandom;
                    if (busy) busy_cycles++;
                    @(posedge clk); #1;
                    cycle++;
                end
            end
            sample_en = 1'b1;
            addr      = samp_addr[i];
            result    = samp_result[i];
            if (we_in_run) begin
                exp_we     = 1'b1;
                exp_idx    = AW'(i);
                exp_addr   = $urandom;
                exp_result = $urandom;
            end
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            cycle++;
        end
        sample_en = 1'b0;
        exp_we    = 1'b0;
        for (int w = 0; w < 20 && done_cycle < 0; w++) begin
            if (done) done_cycle = cycle;
            else begin
                @(posedge clk); #1;
                cycle++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_result = '0;
        trace_len = '0; start = 1'b0; sample_en = 1'b0; addr = '0; result = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
        n_checks++; if (mismatch_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", mismatch_cnt); end
        n_checks++; if (first_fail_idx !== '0) begin n_fail++; $display("[TB] FAIL reset_ffi: got %0d expected 0", first_fail_idx); end
        n_checks++; if (cur_idx !== '0) begin n_fail++; $display("[TB] FAIL reset_cur: got %0d expected 0", cur_idx); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int   dc, bc;
        exp_t e;
        load_entry(0, 32'h0, 32'h5);
        load_entry(1, 32'h4, 32'hA);
        load_entry(2, 32'h8, 32'hF);
        load_entry(3, 32'hC, 32'h14);
        samples_match();
        drive_run(4, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        base_done = dc;
        n_checks++; if (dc !== 4) begin n_fail++; $display("[TB] FAIL basic_done_latency: got %0d expected 4", dc); end
        n_checks++; if (bc !== 4) begin n_fail++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 4", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_low: got %b expected 0", busy); end
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL basic_pass: got %b expected %b", pass, e.pass); end
        n_checks++; if (32'(mismatch_cnt) !== e.cnt) begin n_fail++; $display("[TB] FAIL basic_cnt: got %0d expected %0d", mismatch_cnt, e.cnt); end
        n_checks++; if (32'(cur_idx) !== e.cur) begin n_fail++; $display("[TB] FAIL basic_cur: got %0d expected %0d", cur_idx, e.cur); end
        // Samples presented in DONE must not disturb the held results.
        repeat (2) begin
            sample_en = 1'b1; addr = $urandom; result = $urandom;
            @(posedge clk); #1;
        end
        sample_en = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL done_hold_done: got %b expected 1", done); end
        n_checks++; if (32'(cur_idx) !== e.cur) begin n_fail++; $display("[TB] FAIL done_hold_cur: got %0d expected %0d", cur_idx, e.cur); end
        n_checks++; if (32'(mismatch_cnt) !== e.cnt) begin n_fail++; $display("[TB] FAIL done_hold_cnt: got %0d expected %0d", mismatch_cnt, e.cnt); end
    endtask

    task automatic test_mismatch();
        int   dc, bc;
        exp_t e;
        samples_match();
        samp_result[2] = 32'h10;
        drive_run(4, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL mism_done: got %b expected 1", done); end
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL mism_pass: got %b expected %b", pass, e.pass); end
        n_checks++; if (32'(mismatch_cnt) !== e.cnt) begin n_fail++; $display("[TB] FAIL mism_cnt: got %0d expected %0d", mismatch_cnt, e.cnt); end
        n_checks++; if (32'(first_fail_idx) !== e.ffi) begin n_fail++; $display("[TB] FAIL mism_ffi: got %0d expected %0d", first_fail_idx, e.ffi); end
        samples_match();
    endtask

    task automatic test_stall();
        int   dc, bc;
        exp_t e;
        samples_match();
        drive_run(4, 2, 3, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (dc !== base_done + 3) begin n_fail++; $display("[TB] FAIL stall_done_latency: got %0d expected %0d", dc, base_done + 3); end
        n_checks++; if (bc !== 7) begin n_fail++; $display("[TB] FAIL stall_busy_cycles: got %0d expected 7", bc); end
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL stall_pass: got %b expected %b", pass, e.pass); end
        n_checks++; if (32'(cur_idx) !== e.cur) begin n_fail++; $display("[TB] FAIL stall_cur: got %0d expected %0d", cur_idx, e.cur); end
    endtask

    task automatic test_saturation();
        int   dc, bc;
        exp_t e;
        for (int i = 4; i < DEPTH; i++) load_entry(i, 32'(4 * i), 32'(5 * (i + 1)));
        for (int i = 0; i < DEPTH; i++) begin
            samp_addr[i]   = model_addr[i] ^ 32'h1;
            samp_result[i] = model_result[i];
        end
        drive_run(16, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (32'(mismatch_cnt) !== e.cnt) begin n_fail++; $display("[TB] FAIL sat_cnt_wide: got %0d expected %0d", mismatch_cnt, e.cnt); end
        n_checks++; if (32'(mismatch_cnt_s) !== e.cnt_sat) begin n_fail++; $display("[TB] FAIL sat_cnt_narrow: got %0d expected %0d", mismatch_cnt_s, e.cnt_sat); end
        n_checks++; if (32'(first_fail_idx_s) !== e.ffi) begin n_fail++; $display("[TB] FAIL sat_ffi: got %0d expected %0d", first_fail_idx_s, e.ffi); end
        n_checks++; if (pass_s !== e.pass) begin n_fail++; $display("[TB] FAIL sat_pass: got %b expected %b", pass_s, e.pass); end
        n_checks++; if (32'(cur_idx_s) !== e.cur) begin n_fail++; $display("[TB] FAIL sat_cur: got %0d expected %0d", cur_idx_s, e.cur); end
        samples_match();
    endtask

    task automatic test_clamp();
        int   dc, bc;
        exp_t e;
        samples_match();
        drive_run(20, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (dc !== 16) begin n_fail++; $display("[TB] FAIL clamp_done_latency: got %0d expected 16", dc); end
        n_checks++; if (32'(cur_idx) !== e.cur) begin n_fail++; $display("[TB] FAIL clamp_cur: got %0d expected %0d", cur_idx, e.cur); end
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL clamp_pass: got %b expected %b", pass, e.pass); end
    endtask

    task automatic test_zero_len();
        int   dc, bc;
        exp_t e;
        drive_run(0, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (dc !== 0) begin n_fail++; $display("[TB] FAIL zero_done_latency: got %0d expected 0", dc); end
        n_checks++; if (busy !== 1'b0 || bc !== 0) begin n_fail++; $display("[TB] FAIL zero_busy: got busy=%b cycles=%0d expected 0", busy, bc); end
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL zero_pass: got %b expected %b", pass, e.pass); end
        n_checks++; if (32'(cur_idx) !== e.cur) begin n_fail++; $display("[TB] FAIL zero_cur: got %0d expected %0d", cur_idx, e.cur); end
        n_checks++; if (32'(mismatch_cnt) !== e.cnt) begin n_fail++; $display("[TB] FAIL zero_cnt: got %0d expected %0d", mismatch_cnt, e.cnt); end
    endtask

    task automatic test_reset_mid_run();
        int   dc, bc;
        exp_t e;
        start = 1'b1; trace_len = (AW+1)'(4); sample_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        sample_en = 1'b1; addr = 32'h1234; result = model_result[0];
        @(posedge clk); #1;
        addr = model_addr[1]; result = model_result[1];
        @(posedge clk); #1;
        sample_en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (cur_idx !== '0) begin n_fail++; $display("[TB] FAIL midrst_cur: got %0d expected 0", cur_idx); end
        n_checks++; if (mismatch_cnt !== '0) begin n_fail++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", mismatch_cnt); end
        n_checks++; if (done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done_pass: got %b%b expected 00", done, pass); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        samples_match();
        drive_run(4, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (done !== 1'b1 || pass !== e.pass) begin n_fail++; $display("[TB] FAIL midrst_rerun_pass: got done=%b pass=%b expected done=1 pass=%b", done, pass, e.pass); end
        n_checks++; if (32'(cur_idx) !== e.cur) begin n_fail++; $display("[TB] FAIL midrst_rerun_cur: got %0d expected %0d", cur_idx, e.cur); end
    endtask

    task automatic test_we_in_run();
        int   dc, bc;
        exp_t e;
        samples_match();
        drive_run(4, -1, 0, 1'b1, dc, bc);
        e = sb.pop_front();
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL werun_first_pass: got %b expected %b", pass, e.pass); end
        drive_run(4, -1, 0, 1'b0, dc, bc);
        e = sb.pop_front();
        n_checks++; if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL werun_table_kept: got %b expected %b", pass, e.pass); end
        n_checks++; if (32'(mismatch_cnt) !== e.cnt) begin n_fail++; $display("[TB] FAIL werun_cnt: got %0d expected %0d", mismatch_cnt, e.cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_stall();
        test_saturation();
        test_clamp();
        test_zero_len();
        test_reset_mid_run();
        test_we_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Trace consumer for the single-cycle CPU: samples the CPU's `addr` (PC) and `result` outputs once per retired instruction.
- Compares each sample against an expected-trace table that is preloaded over a write port.
- Reports pass/fail, a mismatch count, and the index of the first mismatch.
- Sits beside the CPU in the simulation top level and in the FPGA self-test wrapper, replacing manual waveform inspection.

Parameters:
- DEPTH, 16, number of expected-trace entries (power of two, 2..256).
- AW, 4, index width; equals log2(DEPTH).
- CW, 8, width of the mismatch counter (saturating).

Ports:
- Clock  in  1  rising-edge clock, same clock as the CPU.
- Reset  in  1  asynchronous, active-low reset.
- exp_we  in  1  write enable for one expected-trace entry.
- exp_idx  in  AW  entry index to write.
- exp_addr  in  32  expected PC for that entry.
- exp_result  in  32  expected result for that entry.
- trace_len  in  AW+1  number of entries to check (0..DEPTH); sampled on start.
- start  in  1  one-cycle pulse that begins a check run.
- sample_en  in  1  the CPU retired an instruction this cycle; `addr`/`result` are valid.
- addr  in  32  CPU PC output.
- result  in  32  CPU result output.
- busy  out  1  high in state RUN.
- done  out  1  high in state DONE.
- pass  out  1  valid when done; 1 means zero mismatches.
- mismatch_cnt  out  CW  number of mismatching samples, saturating.
- first_fail_idx  out  AW  index of the first mismatch; 0 if none.
- cur_idx  out  AW+1  number of samples consumed in this run.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, cur_idx=0.
  - Table contents are NOT cleared by reset; they are undefined until written.
- Table write: on a rising edge with exp_we=1 and state≠RUN, entry[exp_idx] is updated with {exp_addr, exp_result}.
  - exp_we is ignored in RUN.
  - Writes are visible to comparisons from the next cycle.
- State IDLE:
  - start=1 latches len=trace_len, clears mismatch_cnt, first_fail_idx and cur_idx, and clears pass.
  - If len=0: go to DONE with pass=1.
  - If len>DEPTH: treat as DEPTH.
  - Otherwise go to RUN.
- State RUN, each edge with sample_en=1:
  - Compare addr==entry[cur_idx].addr AND result==entry[cur_idx].result (full 32-bit equality on both).
  - On mismatch: mismatch_cnt+=1, saturating at 2^CW-1. If this is the first mismatch of the run, first_fail_idx=cur_idx.
  - cur_idx+=1. When the incremented cur_idx equals len, go to DONE on the same edge.
  - pass=1 if the final mismatch count (including this sample) is 0, else pass=0.
  - sample_en=0 means a CPU stall: no compare and no index advance.
  - start is ignored while in RUN.
- State DONE:
  - done=1; all result outputs hold.
  - start=1 starts a new run exactly as from IDLE (DONE→RUN directly, or DONE→DONE when len=0).
  - sample_en is ignored.
- Simultaneous start and sample_en in IDLE/DONE: only start acts; the sample is discarded.
- Latency:
  - busy rises the cycle after start.
  - done rises the cycle after the edge that consumes the last sample.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-RUN aborts the run immediately and returns to IDLE with all outputs at their reset values.

Test Plan:
- Load 4 entries {(0x0,0x5),(0x4,0xA),(0x8,0xF),(0xC,0x14)}; start with trace_len=4; drive a matching sample each cycle -> busy for 4 cycles, then done=1, pass=1, mismatch_cnt=0, cur_idx=4.
- Same table; make entry 2 mismatch with result=0x10 -> done=1, pass=0, mismatch_cnt=1, first_fail_idx=2.
- Same table; insert sample_en=0 for 3 cycles between samples 1 and 2, with garbage on addr/result during the stall -> still pass=1, cur_idx=4; done rises 3 cycles later than in scenario 1.
- CW=2; 16 entries, all mismatching -> mismatch_cnt saturates at 3, first_fail_idx=0, pass=0.
- start with trace_len=0 -> done=1, pass=1 one cycle later; busy never rises.
- Pull Reset low after 2 samples of a 4-sample run -> outputs reset immediately. Release, then start again -> the table is preserved and the run passes.
- Pulse exp_we during RUN -> table unchanged; verify by checking the original values pass.
